// File: rtl/trap_ctrl.sv
// Trap sequencer between the MEM stage and the machine-mode CSR file.
// Prioritises exceptions, interrupts and mret, strobes the CSR file once, then redirects and flushes.
module trap_ctrl #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned IRQ_CODE = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_valid,
  input  logic [XLEN-1:0] pc_mem,
  input  logic [XLEN-1:0] inst_mem,
  input  logic [XLEN-1:0] dmem_addr,
  input  logic            illegal_inst,
  input  logic            ecall,
  input  logic            l_fault,
  input  logic            s_fault,
  input  logic            mret,
  input  logic            ext_irq,
  input  logic            csr_w,
  input  logic [XLEN-1:0] mstatus,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc_i,
  output logic            is_trap,
  output logic            is_mret,
  output logic [XLEN-1:0] mepc,
  output logic [XLEN-1:0] mcause,
  output logic [XLEN-1:0] mtval,
  output logic            stall,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic [15:0]     trap_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, (XLEN-1)'(IRQ_CODE)};
  localparam logic [XLEN-1:0] VEC_OFF   = XLEN'(4 * IRQ_CODE);

  typedef enum logic [1:0] {IDLE, SAVE, MRET, REDIR} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   cause_q, cause_d;
  logic [XLEN-1:0]   epc_q, epc_d;
  logic [XLEN-1:0]   tval_q, tval_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              exc, irq_take, take_trap, take_mret;
  logic [XLEN-1:0]   sel_cause, sel_tval, sel_target, base;
  logic              unused_mstatus;

  assign unused_mstatus = ^{mstatus[XLEN-1:4], mstatus[2:0]};

  // Event prioritisation; only consulted in IDLE.
  always_comb begin
    exc       = illegal_inst | ecall | l_fault | s_fault;
    irq_take  = ext_irq & mstatus[3];
    take_trap = mem_valid & (exc | irq_take);
    take_mret = mem_valid & mret & ~exc & ~irq_take;
    sel_cause = IRQ_CAUSE;
    sel_tval  = '0;
    if (illegal_inst) begin
      sel_cause = XLEN'(2);
      sel_tval  = inst_mem;
    end else if (ecall) begin
      sel_cause = XLEN'(11);
    end else if (l_fault) begin
      sel_cause = XLEN'(5);
      sel_tval  = dmem_addr;
    end else if (s_fault) begin
      sel_cause = XLEN'(7);
      sel_tval  = dmem_addr;
    end
    base       = {mtvec[XLEN-1:2], 2'b00};
    sel_target = (!exc && mtvec[1:0] == 2'b01) ? base + VEC_OFF : base;
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    epc_d    = epc_q;
    tval_d   = tval_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (take_trap) begin
          cause_d  = sel_cause;
          epc_d    = pc_mem;
          tval_d   = sel_tval;
          target_d = sel_target;
          state_d  = SAVE;
        end else if (take_mret) begin
          state_d = MRET;
        end
      end
      SAVE: begin
        if (!csr_w) begin
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          state_d = REDIR;
        end
      end
      MRET: begin
        // mepc output keeps the value the CSR file rewrote once we leave MRET
        if (!csr_w) begin
          target_d = mepc_i;
          epc_d    = mepc_i;
          state_d  = REDIR;
        end
      end
      REDIR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

  // CSR strobes back off combinationally whenever a pipeline CSR write owns the file.
  assign is_trap        = (state_q == SAVE) & ~csr_w;
  assign is_mret        = (state_q == MRET) & ~csr_w;
  assign stall          = (state_q == SAVE) | (state_q == MRET);
  assign redirect_valid = (state_q == REDIR);
  assign flush          = (state_q == REDIR);
  assign redirect_pc    = (state_q == REDIR) ? target_q : '0;
  assign mepc           = (state_q == MRET) ? mepc_i : epc_q;
  assign mcause         = cause_q;
  assign mtval          = tval_q;
  assign trap_cnt       = cnt_q;

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Trap sequencer that sits between the pipeline's MEM stage and the machine-mode CSR file.
- Collects synchronous exceptions, the external interrupt and mret from the instruction in MEM, and prioritises them.
- Latches the trap record and drives the CSR file's is_trap/is_mret/mepc/mcause/mtval inputs for exactly one accepted cycle.
- Then issues a one-cycle PC redirect plus flush to mtvec or mepc.
- Stalls the pipeline while a trap is in flight.
- Defers CSR update while a pipeline CSR write owns the CSR file, because CSR writes take priority there.

Parameters:
- XLEN, 32, data/address width.
- IRQ_CODE, 11, mcause exception code for the external interrupt (interrupt bit 31 set).

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- mem_valid  in  1  MEM-stage instruction valid; qualifies all event inputs.
- pc_mem  in  XLEN  PC of MEM instruction.
- inst_mem  in  XLEN  instruction word in MEM.
- dmem_addr  in  XLEN  data address of MEM instruction.
- illegal_inst  in  1  illegal-instruction exception.
- ecall  in  1  ecall executed.
- l_fault  in  1  load access fault.
- s_fault  in  1  store/AMO access fault.
- mret  in  1  mret executed.
- ext_irq  in  1  external interrupt request, level.
- csr_w  in  1  pipeline CSR write this cycle; CSR file is busy.
- mstatus  in  XLEN  from CSR file.
- mtvec  in  XLEN  from CSR file.
- mepc_i  in  XLEN  current mepc from CSR file.
- is_trap  out  1  to CSR file.
- is_mret  out  1  to CSR file.
- mepc  out  XLEN  to CSR file.
- mcause  out  XLEN  to CSR file.
- mtval  out  XLEN  to CSR file.
- stall  out  1  freeze IF..MEM.
- redirect_valid  out  1  one-cycle PC override.
- redirect_pc  out  XLEN  target PC.
- flush  out  1  kill IF..MEM contents; asserted together with redirect_valid.
- trap_cnt  out  16  number of traps committed (mret excluded).

Behaviour:
- Reset is rst, asynchronous, active-high; clock is clk.
- On reset:
  - state = IDLE.
  - All outputs 0, including trap_cnt and the latched record.
  - Reset asserted in any state aborts the sequence immediately; no CSR strobe or redirect is emitted afterwards.
- Event selection happens in IDLE only, when mem_valid = 1. Priority is highest first:
  1. illegal_inst: cause 2, tval = inst_mem.
  2. ecall: cause 11, tval = 0.
  3. l_fault: cause 5, tval = dmem_addr.
  4. s_fault: cause 7, tval = dmem_addr.
  5. ext_irq with mstatus[3] = 1: cause 0x8000_0000 | IRQ_CODE, tval = 0.
  6. mret.
- Selection side rules:
  - epc = pc_mem for every trap.
  - Any exception or interrupt suppresses a simultaneous mret.
  - ext_irq with MIE = 0 is ignored.
- Trap target:
  - base = {mtvec[XLEN-1:2], 2'b00}.
  - If mtvec[1:0] = 01 and the trap is an interrupt, target = base + 4*IRQ_CODE; otherwise target = base.
  - Arithmetic is modulo 2^XLEN.
- States:
  - IDLE: on a selected trap, latch cause/epc/tval/target and go to SAVE. On a selected mret, go to MRET. stall = 0 here.
  - SAVE:
    - stall = 1; mepc/mcause/mtval driven from latch.
    - is_trap = !csr_w.
    - If csr_w = 1, remain in SAVE: the record is retried and MIE/MPIE are toggled exactly once.
    - Otherwise increment trap_cnt (saturate at 0xFFFF) and go to REDIR.
  - MRET:
    - stall = 1; is_mret = !csr_w.
    - mepc = mepc_i, so the CSR file rewrites mepc unchanged. mcause and mtval are held at their last-latched values.
    - Latch target = mepc_i on the accepted cycle. If csr_w = 1, remain in MRET; otherwise go to REDIR.
  - REDIR: redirect_valid = 1, flush = 1, stall = 0, redirect_pc = target. Next state is IDLE.
- Event inputs are ignored in SAVE, MRET and REDIR; the flushed instructions' events are discarded.
- Latency is fixed in the uncontended case:
  - Trap: event in IDLE at cycle N → is_trap at N+1 → redirect at N+2.
  - Each cycle with csr_w = 1 in SAVE or MRET adds one cycle.
- is_trap and is_mret are never both 1. Neither is ever 1 while csr_w = 1.
- mepc/mcause/mtval hold their last values outside SAVE/MRET.

Test Plan:
1. Illegal instruction: pc_mem = 0x100, inst_mem = 0xFFFF_FFFF, mtvec = 0x200, mem_valid = 1 → next cycle is_trap = 1, mcause = 2, mepc = 0x100, mtval = 0xFFFF_FFFF; following cycle redirect_pc = 0x200 with flush = 1; trap_cnt = 1.
2. Priority: illegal_inst, ecall and ext_irq all set with MIE = 1 → mcause = 2. Repeat with only ecall + mret → mcause = 11 and is_mret never asserted.
3. Vectored interrupt: mtvec = 0x401 (mode 1), ext_irq = 1, mstatus = 0x8, pc_mem = 0x40 → mcause = 0x8000_000B, mepc = 0x40, redirect_pc = 0x42C. Same stimulus with mstatus = 0 → no trap.
4. CSR contention: ecall arrives while csr_w is held high for 2 cycles → stall high, is_trap low during those cycles, is_trap high for exactly 1 cycle after csr_w drops, then redirect; total latency 4 cycles.
5. mret: mepc_i = 0x1234, mret = 1 → is_mret = 1 for one cycle with mepc = 0x1234, then redirect_pc = 0x1234; trap_cnt unchanged.
6. Reset mid-sequence: assert rst in the SAVE cycle → all outputs 0 immediately; after release there is no redirect and trap_cnt = 0.
